// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   typedef enum logic {FETCH, FAULT} fetch_state_t;
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic        valid;
   } if_id_t;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: memory, redirect and decode handshake signals of the fetch stage
interface instr_fetch_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        fetch_fault;
   logic [31:0] fetch_cnt;
   modport master (
      output imem_addr, id_valid, id_inst, id_pc, id_pc_plus4, fetch_fault, fetch_cnt,
      input  imem_inst, redirect_valid, redirect_pc, id_ready
   );
   modport slave (
      input  imem_addr, id_valid, id_inst, id_pc, id_pc_plus4, fetch_fault, fetch_cnt,
      output imem_inst, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and IF/ID register with stall, redirect and range-fault halt
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 10
) (
   input logic          clk,
   input logic          rst_n,
   instr_fetch_if.master bus
);
   fetch_state_t state, state_n;
   if_id_t       id_q, id_n;
   logic [31:0]  pc, pc_n, cnt;
   logic         fault, fault_n, fire, in_range;
   assign bus.imem_addr   = pc;
   assign bus.id_valid    = id_q.valid;
   assign bus.id_inst     = id_q.inst;
   assign bus.id_pc       = id_q.pc;
   assign bus.id_pc_plus4 = id_q.pc_plus4;
   assign bus.fetch_fault = fault;
   assign bus.fetch_cnt   = cnt;
   assign in_range = (pc >> 2) < IMEM_WORDS;
   assign fire     = (state == FETCH) && (!id_q.valid || bus.id_ready) && !bus.redirect_valid;
   // redirect wins over everything, including a stalled decode
   always_comb begin
      state_n = state;
      pc_n    = pc;
      id_n    = id_q;
      fault_n = fault;
      if (bus.redirect_valid) begin
         state_n = FETCH;
         pc_n    = {bus.redirect_pc[31:2], 2'b00};
         id_n    = '{inst: NOP_INST, pc: id_q.pc, pc_plus4: id_q.pc_plus4, valid: 1'b0};
         fault_n = 1'b0;
      end else if (fire && in_range) begin
         pc_n = pc + 32'd4;
         id_n = '{inst: bus.imem_inst, pc: pc, pc_plus4: pc + 32'd4, valid: 1'b1};
      end else if (fire) begin
         state_n    = FAULT;
         fault_n    = 1'b1;
         id_n.valid = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= FETCH;
         pc    <= RESET_PC;
         id_q  <= '{inst: NOP_INST, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};
         fault <= 1'b0;
         cnt   <= 32'd0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         id_q  <= id_n;
         fault <= fault_n;
         cnt   <= cnt + 32'(id_q.valid & bus.id_ready);
      end
endmodule
